// File: rtl/byte_frame_parser.sv
`default_nettype none
// ============================================================================
// Module      : byte_frame_parser
// Description : Pops bytes from a prefetch FIFO, hunts for a HDR0/HDR1
//               header, forwards the length-prefixed payload with SOF/EOF
//               framing and checks a trailing 8-bit additive checksum.
//               Optional mid-frame idle timeout: define PARSER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_frame_parser #(
    parameter logic [7:0] HDR0        = 8'h55,
    parameter logic [7:0] HDR1        = 8'hAA,
    parameter int         MAX_LEN     = 255,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_rd_vld,
    input  logic [7:0]  fifo_rd_data,
    output logic        fifo_rd_en,
    input  logic        out_rdy,
    output logic        out_vld,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] good_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4
    } state_t;

    localparam logic [8:0] c_max_len = 9'(MAX_LEN);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_sum;
    logic [7:0]  w_sum_nxt;
    logic [7:0]  r_remaining;
    logic [7:0]  w_remaining_nxt;
    logic        r_first;
    logic        w_first_nxt;
    logic        w_load_out;
    logic        w_done_nxt;
    logic        w_err_nxt;
    logic        w_pop;
    logic        w_timeout;

    logic        r_out_vld;
    logic [7:0]  r_out_data;
    logic        r_out_sof;
    logic        r_out_eof;
    logic        r_frame_done;
    logic        r_frame_err;
    logic [15:0] r_good_cnt;
    logic [15:0] r_err_cnt;

    // Only PAYLOAD is back-pressured; pops are suppressed while held in reset.
    assign fifo_rd_en = rst_n & ((r_state == S_PAYLOAD) ? (~r_out_vld | out_rdy) : 1'b1);
    assign w_pop      = fifo_rd_en & fifo_rd_vld;

`ifdef PARSER_TIMEOUT_EN
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_cnt <= 16'd0;
        end else if ((r_state == S_IDLE) || w_pop) begin
            r_idle_cnt <= 16'd0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    assign w_timeout = (r_state != S_IDLE) && !w_pop && (r_idle_cnt == c_timeout_last);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sum_nxt       = r_sum;
        w_remaining_nxt = r_remaining;
        w_first_nxt     = r_first;
        w_load_out      = 1'b0;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_err_nxt   = 1'b1;
        end else if (w_pop) begin
            case (r_state)
                S_IDLE: begin
                    if (fifo_rd_data == HDR0) w_state_nxt = S_HDR;
                end
                S_HDR: begin
                    if (fifo_rd_data == HDR1)      w_state_nxt = S_LEN;
                    else if (fifo_rd_data != HDR0) w_state_nxt = S_IDLE;
                end
                S_LEN: begin
                    w_sum_nxt = fifo_rd_data;
                    if ({1'b0, fifo_rd_data} > c_max_len) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end else if (fifo_rd_data == 8'd0) begin
                        w_state_nxt = S_CSUM;
                    end else begin
                        w_state_nxt     = S_PAYLOAD;
                        w_remaining_nxt = fifo_rd_data;
                        w_first_nxt     = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    w_load_out      = 1'b1;
                    w_sum_nxt       = r_sum + fifo_rd_data;
                    w_remaining_nxt = r_remaining - 8'd1;
                    w_first_nxt     = 1'b0;
                    if (r_remaining == 8'd1) w_state_nxt = S_CSUM;
                end
                S_CSUM: begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = (fifo_rd_data != r_sum);
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sum       <= 8'd0;
            r_remaining <= 8'd0;
            r_first     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sum       <= w_sum_nxt;
            r_remaining <= w_remaining_nxt;
            r_first     <= w_first_nxt;
        end
    end

    // A new byte is only loaded when the register is empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld  <= 1'b0;
            r_out_data <= 8'd0;
            r_out_sof  <= 1'b0;
            r_out_eof  <= 1'b0;
        end else if (w_load_out) begin
            r_out_vld  <= 1'b1;
            r_out_data <= fifo_rd_data;
            r_out_sof  <= r_first;
            r_out_eof  <= (r_remaining == 8'd1);
        end else if (out_rdy) begin
            r_out_vld  <= 1'b0;
            r_out_sof  <= 1'b0;
            r_out_eof  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_good_cnt   <= 16'd0;
            r_err_cnt    <= 16'd0;
        end else begin
            r_frame_done <= w_done_nxt;
            r_frame_err  <= w_err_nxt;
            if (w_done_nxt) begin
                if (w_err_nxt) begin
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                end else begin
                    if (r_good_cnt != 16'hFFFF) r_good_cnt <= r_good_cnt + 16'd1;
                end
            end
        end
    end

    assign out_vld    = r_out_vld;
    assign out_data   = r_out_data;
    assign out_sof    = r_out_sof;
    assign out_eof    = r_out_eof;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign good_cnt   = r_good_cnt;
    assign err_cnt    = r_err_cnt;

endmodule
`default_nettype wire
